// File: rtl/sd_cmd_xfer_if.sv
// Request/response handshake between a host and the SD SPI command engine.
// The host drives the request fields; the engine returns status and captured response bytes.
interface sd_cmd_xfer_if;
  logic        start;
  logic [5:0]  command;
  logic [31:0] argument;
  logic [2:0]  resp_len;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [39:0] resp;

  modport master (
    output start, command, argument, resp_len,
    input  busy, done, timeout, resp
  );

  modport slave (
    input  start, command, argument, resp_len,
    output busy, done, timeout, resp
  );
endinterface

// File: rtl/sd_cmd_xfer.sv
// SPI-mode SD command engine: sends a 48-bit command frame with CRC7, polls for the R1 start
// byte, captures up to RESP_MAX response bytes and pulses done.
module sd_cmd_xfer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned RESP_MAX = 5,
  parameter int unsigned NCR_MAX  = 8
) (
  input  logic         clock,
  input  logic         reset,
  sd_cmd_xfer_if.slave bus,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n
);

  typedef enum logic [2:0] {StIdle, StPre, StCmd, StPoll, StResp, StPost, StFin} state_e;

  localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
  localparam logic [7:0] PollLast = 8'(NCR_MAX - 1);
  localparam logic [2:0] RespMax  = 3'(RESP_MAX);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic [5:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [7:0]  poll_q, poll_d;
  logic [2:0]  rlen_q, rlen_d;
  logic [47:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [39:0] resp_q, resp_d;
  logic        timeout_q, timeout_d;

  logic        active, tick, rise, fall, bit_end;
  logic [5:0]  bit_last;
  logic [39:0] frame_head;

  // Serial CRC7, x^7 + x^3 + 1, zero seed, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  assign active     = (state_q != StIdle) && (state_q != StFin);
  assign tick       = active && (div_q == DivLast);
  assign rise       = tick && !sclk_q;
  assign fall       = tick && sclk_q;
  assign bit_last   = (state_q == StCmd) ? 6'd47 : 6'd7;
  assign bit_end    = fall && (bit_q == bit_last);
  assign frame_head = {2'b01, bus.command, bus.argument};

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    poll_d    = poll_q;
    rlen_d    = rlen_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;

    // Bit clock: SCLK low for the first half of each bit, high for the second.
    if (active) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + 8'd1;
      end
      if (rise) rx_d = {rx_q[6:0], miso};
      if (fall) begin
        bit_d = bit_end ? 6'd0 : bit_q + 6'd1;
        if (state_q == StCmd) tx_d = {tx_q[46:0], 1'b0};
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StPre;
          tx_d      = {frame_head, crc7(frame_head), 1'b1};
          rlen_d    = (bus.resp_len == 3'd0)   ? 3'd1    :
                      (bus.resp_len > RespMax) ? RespMax : bus.resp_len;
          resp_d    = '0;
          timeout_d = 1'b0;
          div_d     = '0;
          sclk_d    = 1'b0;
          bit_d     = '0;
          byte_d    = '0;
          poll_d    = '0;
        end
      end
      StPre:  if (bit_end) state_d = StCmd;
      StCmd:  if (bit_end) state_d = StPoll;
      StPoll: begin
        if (bit_end) begin
          if (!rx_q[7]) begin
            resp_d[39:32] = rx_q;
            byte_d        = 3'd1;
            state_d       = (rlen_q == 3'd1) ? StPost : StResp;
          end else if (poll_q == PollLast) begin
            timeout_d = 1'b1;
            state_d   = StPost;
          end else begin
            poll_d = poll_q + 8'd1;
          end
        end
      end
      StResp: begin
        if (bit_end) begin
          for (int i = 1; i < 5; i++) begin
            if (byte_q == 3'(i)) resp_d[8*(4-i) +: 8] = rx_q;
          end
          if (byte_q == rlen_q - 3'd1) state_d = StPost;
          else                         byte_d  = byte_q + 3'd1;
        end
      end
      StPost: if (bit_end) state_d = StFin;
      StFin: begin
        state_d = StIdle;
        byte_d  = '0;
        poll_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      bit_q     <= '0;
      byte_q    <= '0;
      poll_q    <= '0;
      rlen_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      poll_q    <= poll_d;
      rlen_q    <= rlen_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  assign sclk        = sclk_q;
  assign cs_n        = !active;
  assign mosi        = (state_q == StCmd) ? tx_q[47] : 1'b1;
  assign bus.busy    = active;
  assign bus.done    = (state_q == StFin);
  assign bus.timeout = timeout_q;
  assign bus.resp    = resp_q;

endmodule

// File: tb/tb_sd_cmd_xfer.sv
// Bench for sd_cmd_xfer: two instances (CLK_DIV 7 and 1) share stimulus; an SD card model
// feeds miso from a planned byte stream and the host side is checked against a reference model.
module tb_sd_cmd_xfer;

  localparam int NcrMax = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_v [2];
  logic [5:0]  cmd_v;
  logic [31:0] arg_v;
  logic [2:0]  rl_v;
  logic [0:255] stream;
  logic        clr;

  logic        busy_o [2], done_o [2], timeout_o [2], sclk_o [2], mosi_o [2], cs_n_o [2];
  logic [39:0] resp_o [2];
  logic [47:0] frame [2];
  int          busy_cyc [2], done_cnt [2], rises [2], mosi_zero [2], per_bad [2], idle_edges [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  function automatic int div_of(input int g);
    return (g == 0) ? 7 : 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 7 : 1;
    sd_cmd_xfer_if bus ();
    logic sclk, mosi, miso, cs_n;
    int   nb = 0, nr = 0, zeros = 0, bcyc = 0, dcnt = 0, pbad = 0, iedge = 0, cyc = 0, last = 0;
    logic have = 1'b0, sclk_prev = 1'b0;
    logic [47:0] frm = '0;

    assign bus.start    = start_v[g];
    assign bus.command  = cmd_v;
    assign bus.argument = arg_v;
    assign bus.resp_len = rl_v;

    sd_cmd_xfer #(.CLK_DIV(D), .RESP_MAX(5), .NCR_MAX(NcrMax)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .sclk  (sclk),
      .mosi  (mosi),
      .miso  (miso),
      .cs_n  (cs_n)
    );

    // Card model: next stream bit appears after each SCLK falling edge.
    assign miso = stream[nb[7:0]];
    always @(negedge sclk or posedge cs_n) begin
      if (cs_n) nb <= 0;
      else      nb <= nb + 1;
    end

    always @(posedge sclk or negedge cs_n) begin
      if (!sclk) begin
        nr    <= 0;
        zeros <= 0;
      end else if (cs_n) begin
        iedge <= iedge + 1;
      end else begin
        if (nr >= 8 && nr < 56) frm   <= {frm[46:0], mosi};
        else if (!mosi)         zeros <= zeros + 1;
        nr <= nr + 1;
      end
    end

    always @(negedge clock) begin
      cyc       <= cyc + 1;
      sclk_prev <= sclk;
      if (clr) begin
        bcyc <= 0;
        dcnt <= 0;
      end else begin
        if (bus.busy) bcyc <= bcyc + 1;
        if (bus.done) dcnt <= dcnt + 1;
      end
      if (sclk && !sclk_prev) begin
        if (have && (cyc - last) != 2 * D) pbad <= pbad + 1;
        last <= cyc;
        have <= 1'b1;
      end else if (cs_n) begin
        have <= 1'b0;
      end
    end

    assign busy_o[g]     = bus.busy;
    assign done_o[g]     = bus.done;
    assign timeout_o[g]  = bus.timeout;
    assign resp_o[g]     = bus.resp;
    assign sclk_o[g]     = sclk;
    assign mosi_o[g]     = mosi;
    assign cs_n_o[g]     = cs_n;
    assign frame[g]      = frm;
    assign busy_cyc[g]   = bcyc;
    assign done_cnt[g]   = dcnt;
    assign rises[g]      = nr;
    assign mosi_zero[g]  = zeros;
    assign per_bad[g]    = pbad;
    assign idle_edges[g] = iedge;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC7 by polynomial long division of msg * x^7 by 0x89.
  function automatic logic [6:0] model_crc(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  task automatic check_idle_outputs(input string tag, input int g);
    check({tag, " busy"},    64'(busy_o[g]),    64'd0);
    check({tag, " done"},    64'(done_o[g]),    64'd0);
    check({tag, " timeout"}, 64'(timeout_o[g]), 64'd0);
    check({tag, " resp"},    64'(resp_o[g]),    64'd0);
    check({tag, " sclk"},    64'(sclk_o[g]),    64'd0);
    check({tag, " mosi"},    64'(mosi_o[g]),    64'd1);
    check({tag, " cs_n"},    64'(cs_n_o[g]),    64'd1);
  endtask

  task automatic launch(input logic [5:0] cmd, input logic [31:0] arg, input logic [2:0] rl,
                        input int nff, input logic [39:0] rbytes);
    stream = '1;
    for (int i = 0; i < 5; i++) stream[56 + 8*nff + 8*i +: 8] = rbytes[39 - 8*i -: 8];
    @(posedge clock); #1;
    clr = 1'b1;
    @(posedge clock); #1;
    cmd_v = cmd;
    arg_v = arg;
    rl_v  = rl;
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    @(posedge clock); #1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    clr   = 1'b0;
    cmd_v = 6'($urandom);
    arg_v = $urandom;
    rl_v  = 3'($urandom);
  endtask

  task automatic run_txn(input logic [5:0] cmd, input logic [31:0] arg, input logic [2:0] rl,
                         input int nff, input logic [39:0] rbytes);
    int          erl, polls, bits;
    logic        to;
    logic [39:0] eresp, m;
    logic [47:0] eframe;
    logic        seen [2];

    erl   = (rl == 0) ? 1 : (rl > 5) ? 5 : int'(rl);
    to    = (nff >= NcrMax);
    polls = to ? NcrMax : nff + 1;
    bits  = 8 + 48 + 8 * polls + (to ? 0 : 8 * (erl - 1)) + 8;
    eresp = '0;
    if (!to) for (int i = 0; i < erl; i++) eresp[39 - 8*i -: 8] = rbytes[39 - 8*i -: 8];
    m      = {2'b01, cmd, arg};
    eframe = {m, model_crc(m), 1'b1};

    launch(cmd, arg, rl, nff, rbytes);
    for (int g = 0; g < 2; g++) begin
      check("busy after accept", 64'(busy_o[g]), 64'd1);
      check("resp cleared on accept", 64'(resp_o[g]), 64'd0);
      check("timeout cleared on accept", 64'(timeout_o[g]), 64'd0);
    end

    seen[0] = 1'b0;
    seen[1] = 1'b0;
    for (int k = 0; k < 20000 && !(seen[0] && seen[1]); k++) begin
      @(negedge clock);
      for (int g = 0; g < 2; g++) begin
        start_v[g] = 1'b0;
        if (done_o[g]) begin
          seen[g] = 1'b1;
          check("resp at done", 64'(resp_o[g]), 64'(eresp));
          check("timeout at done", 64'(timeout_o[g]), 64'(to));
          start_v[g] = 1'b1;  // lands in the FIN cycle
        end else if (busy_o[g] && (k == 100 || k == 300)) begin
          start_v[g] = 1'b1;
          cmd_v      = 6'($urandom);
          arg_v      = $urandom;
        end
      end
    end
    @(posedge clock); #1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    repeat (3) @(negedge clock);

    for (int g = 0; g < 2; g++) begin
      check("done seen", 64'(seen[g]), 64'd1);
      check("mosi frame", 64'(frame[g]), 64'(eframe));
      check("mosi ones outside frame", 64'(mosi_zero[g]), 64'd0);
      check("sclk bit count", 64'(rises[g]), 64'(bits));
      check("busy cycles", 64'(busy_cyc[g]), 64'(bits * 2 * div_of(g)));
      check("done pulses", 64'(done_cnt[g]), 64'd1);
      check("idle after FIN start", 64'(busy_o[g]), 64'd0);
      check("resp hold", 64'(resp_o[g]), 64'(eresp));
      check("timeout hold", 64'(timeout_o[g]), 64'(to));
    end
  endtask

  initial begin
    logic [63:0] r64;
    logic [39:0] rb;
    int          nff;

    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    cmd_v      = '0;
    arg_v      = '0;
    rl_v       = '0;
    clr        = 1'b1;
    stream     = '1;
    #1;
    for (int g = 0; g < 2; g++) check_idle_outputs("reset", g);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    run_txn(6'd0, 32'h0, 3'd1, 2, 40'h01_0000_0000);
    check("CMD0 frame", 64'(frame[0]), 64'h4000_0000_0095);
    run_txn(6'd8, 32'h0000_01AA, 3'd5, 1, 40'h01_0000_01AA);
    check("CMD8 crc byte", 64'(frame[0][7:0]), 64'h87);
    check("CMD8 resp", 64'(resp_o[1]), 64'h01_0000_01AA);
    run_txn(6'd17, 32'h1234_5678, 3'd3, 8, 40'h00_1122_3344);
    check("timeout flag", 64'(timeout_o[0]), 64'd1);
    run_txn(6'd55, 32'hDEAD_BEEF, 3'd2, 7, 40'h05_A5C3_0000);
    run_txn(6'd13, 32'h0, 3'd0, 0, 40'h7F_FFFF_FFFF);
    run_txn(6'd58, 32'hFFFF_FFFF, 3'd7, 3, 40'h00_8001_7EFE);

    for (int t = 0; t < 6; t++) begin
      r64     = {$urandom, $urandom};
      rb      = r64[39:0];
      rb[39]  = 1'b0;
      nff     = $urandom_range(0, 9);
      run_txn(6'($urandom), $urandom, 3'($urandom_range(0, 7)), nff, rb);
    end

    // Reset mid-POLL on the slow instance must abort silently.
    launch(6'd1, 32'h0, 3'd1, 20, 40'hFF_FFFF_FFFF);
    repeat (850) @(negedge clock);
    reset = 1'b1;
    #1;
    check_idle_outputs("reset mid-poll", 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("no done after abort", 64'(done_cnt[0]), 64'd0);
    check("idle after abort", 64'(busy_o[0]), 64'd0);
    run_txn(6'd41, 32'h4030_0000, 3'd1, 1, 40'h00_0000_0000);

    for (int g = 0; g < 2; g++) begin
      check("sclk period", 64'(per_bad[g]), 64'd0);
      check("no sclk while cs_n high", 64'(idle_edges[g]), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd_cmd_xfer.md
SD_CMD_XFER -- requirements
Module: sd_cmd_xfer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: system clocks per SCLK half-period, legal range 1..255.
REQ-002 SHALL have parameter RESP_MAX, default 5: maximum response bytes captured, legal range 1..5.
REQ-003 SHALL have parameter NCR_MAX, default 8: maximum 0xFF polling bytes before timeout, legal range 1..255.
REQ-004 SHALL have port: clock  input  1  system clock, rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 SHALL have port: command  input  6  command index.
REQ-008 SHALL have port: argument  input  32  command argument.
REQ-009 SHALL have port: resp_len  input  3  response bytes to capture, 1..RESP_MAX.
REQ-010 SHALL have port: busy  output  1  high from accepted start until done.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: timeout  output  1  valid with done; no response start bit seen.
REQ-013 SHALL have port: resp  output  40  captured bytes, first byte in [39:32], left-aligned, unused bytes 0.
REQ-014 SHALL have ports: sclk  output  1; mosi  output  1; miso  input  1; cs_n  output  1.

Function
REQ-015 SHALL use SPI mode 0: mosi changes after SCLK falling edge; miso sampled on SCLK rising edge; one bit time = 2*CLK_DIV clocks; SCLK idles low.
REQ-016 SHALL latch command, argument and resp_len on the clock edge that accepts start; later input changes SHALL NOT affect the transfer.
REQ-017 SHALL compute CRC7 (polynomial x^7+x^3+1, zero init) over the first 40 frame bits {2'b01, command, argument}, and send the final byte as {crc7, 1'b1}.
REQ-018 SHALL implement states IDLE -> PRE -> CMD -> POLL -> RESP -> POST -> FIN -> IDLE.
REQ-019 PRE: cs_n low, 8 bits of mosi=1 sent.
REQ-020 CMD: 48 frame bits sent MSB first.
REQ-021 POLL: bytes sent with mosi=1, MSB first; a received byte whose first bit (bit 7) is 0 SHALL be stored as response byte 0. If resp_len=1 the state SHALL go to POST, otherwise to RESP.
REQ-022 POLL: after NCR_MAX bytes with no start bit, timeout SHALL be set, resp SHALL be 0, and the state SHALL go to POST.
REQ-023 RESP: resp_len-1 further bytes captured with mosi=1, MSB first.
REQ-024 POST: 8 bits of mosi=1 sent with cs_n low; then cs_n is raised and SCLK stops low.
REQ-025 FIN: done=1 for exactly one clock; busy falls on the same clock.
REQ-026 SHALL hold resp and timeout stable from done until the next accepted start; both SHALL clear on accept.
REQ-027 SHALL ignore start while busy, including start asserted in the FIN cycle.
REQ-028 SHALL treat resp_len of 0 as 1, and resp_len greater than RESP_MAX as RESP_MAX.
REQ-029 In IDLE, mosi SHALL be 1, cs_n SHALL be 1 and sclk SHALL be 0.

Reset
REQ-030 On reset assertion, all outputs SHALL immediately return to: busy=0, done=0, timeout=0, resp=0, sclk=0, mosi=1, cs_n=1; the state SHALL be IDLE and all counters SHALL be 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer without a done pulse; the first start after reset deassertion SHALL be accepted normally.

Verification
REQ-032 CMD0, argument 0x00000000, resp_len=1, miso model returns 0x01 after 2 0xFF bytes -> mosi frame 0x400000000095, resp=0x0100000000, timeout=0, one done pulse.
REQ-033 CMD8, argument 0x000001AA, resp_len=5, model returns 01 00 00 01 AA -> CRC byte 0x87, resp=0x01000001AA.
REQ-034 miso held 1, NCR_MAX=8 -> exactly 8 poll bytes, timeout=1, resp=0, then POST and done.
REQ-035 CLK_DIV=1 and CLK_DIV=7 -> measured SCLK period 2 and 14 clocks; no SCLK edges while cs_n=1; total transfer = (8+48+8*polls+8*(resp_len-1)+8) bit times plus FIN.
REQ-036 start pulsed during CMD, and again in the FIN cycle -> both ignored; reset asserted during POLL -> outputs at reset values next cycle, no done; fresh start completes correctly.
